// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with a single-cycle ALU/branch path and an
// iterative radix-2 multiply/divide unit sharing one registered output slot.
module ex_stage_mc #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3,
    parameter int SEL_W   = $clog2(NUM_FWD + 3)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic [XLEN-1:0]         pc,
    input  logic [XLEN-1:0]         imm,
    input  logic [XLEN-1:0]         rega,
    input  logic [XLEN-1:0]         regb,
    input  logic [SEL_W-1:0]        opa_sel,
    input  logic [SEL_W-1:0]        opb_sel,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic [3:0]              alu_func,
    input  logic                    is_md,
    input  logic [2:0]              md_op,
    input  logic                    cond_branch,
    input  logic                    uncond_branch,
    input  logic [2:0]              funct3,
    input  logic [XLEN-1:0]         pc_add_opa,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_result,
    output logic [XLEN-1:0]         out_target_pc,
    output logic                    out_take_branch,
    output logic                    busy
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0]   opa, opb, alu_res, md_res, mag_a, mag_b, mcand, quo, rem;
    logic [SH_W-1:0]   sh;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, acc_nxt, prod;
    logic [XLEN:0]     sum, rem_sh;
    logic [2:0]        op_q;
    logic              cond, accept, last, ge, a_neg, b_neg, neg_q, rneg_q, div0_q;

    always_comb begin
        opa = opa_sel == SEL_W'(1) ? pc  : opa_sel == SEL_W'(2) ? '0       : rega;
        opb = opb_sel == SEL_W'(1) ? imm : opb_sel == SEL_W'(2) ? XLEN'(4) : regb;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (opa_sel == SEL_W'(3 + k)) opa = fwd_data[k*XLEN +: XLEN];
            if (opb_sel == SEL_W'(3 + k)) opb = fwd_data[k*XLEN +: XLEN];
        end
    end

    always_comb begin
        sh = opb[SH_W-1:0];
        case (alu_func)
            4'd0:    alu_res = opa + opb;
            4'd1:    alu_res = opa - opb;
            4'd2:    alu_res = opa & opb;
            4'd3:    alu_res = opa | opb;
            4'd4:    alu_res = opa ^ opb;
            4'd5:    alu_res = opa << sh;
            4'd6:    alu_res = opa >> sh;
            4'd7:    alu_res = $signed(opa) >>> sh;
            4'd8:    alu_res = XLEN'($signed(opa) < $signed(opb));
            4'd9:    alu_res = XLEN'(opa < opb);
            default: alu_res = '0;
        endcase
    end

    assign cond = funct3 == 3'd0 ? rega == regb :
                  funct3 == 3'd1 ? rega != regb :
                  funct3 == 3'd4 ? $signed(rega) <  $signed(regb) :
                  funct3 == 3'd5 ? $signed(rega) >= $signed(regb) :
                  funct3 == 3'd6 ? rega <  regb :
                  funct3 == 3'd7 ? rega >= regb : 1'b0;

    // Iterate on magnitudes; signs are re-applied when the result is formed.
    assign a_neg = md_op inside {3'd1, 3'd2, 3'd4, 3'd6} && opa[XLEN-1];
    assign b_neg = md_op inside {3'd1, 3'd4, 3'd6} && opb[XLEN-1];
    assign mag_a = a_neg ? -opa : opa;
    assign mag_b = b_neg ? -opb : opb;

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        ge      = rem_sh >= {1'b0, mcand};
        acc_nxt = op_q[2] ? {rem_sh[XLEN-1:0] - (ge ? mcand : '0), acc[XLEN-2:0], ge}
                          : {sum, acc[XLEN-1:1]};
        prod    = neg_q ? -acc_nxt : acc_nxt;
        quo     = acc_nxt[XLEN-1:0];
        rem     = acc_nxt[2*XLEN-1:XLEN];
        md_res  = !op_q[2] ? (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                  !op_q[1] ? (neg_q && !div0_q ? -quo : quo) :
                             (rneg_q ? -rem : rem);
    end

    assign busy     = state == BUSY;
    assign last     = busy && cnt == CNT_W'(XLEN - 1);
    assign in_ready = rst && state == IDLE && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = flush ? IDLE : (accept && is_md) ? BUSY : last ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            cnt <= (busy && !last && !flush) ? cnt + 1'b1 : '0;
            if (accept && is_md) begin
                acc    <= {{XLEN{1'b0}}, md_op[2] ? mag_a : mag_b};
                mcand  <= md_op[2] ? mag_b : mag_a;
                op_q   <= md_op;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                div0_q <= md_op[2] && opb == '0;
            end else if (busy) begin
                acc <= acc_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_target_pc   <= '0;
            out_take_branch <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !is_md) begin
            out_valid       <= 1'b1;
            out_result      <= alu_res;
            out_target_pc   <= pc_add_opa + imm;
            out_take_branch <= uncond_branch | (cond_branch & cond);
        end else if (last) begin
            out_valid       <= 1'b1;
            out_result      <= md_res;
            out_target_pc   <= '0;
            out_take_branch <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: random and directed stimulus against a cycle-level reference
// model built from plain 64-bit arithmetic.
module tb_ex_stage_mc;
    localparam int XLEN = 32, NUM_FWD = 3, SEL_W = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [XLEN-1:0] pc = '0, imm = '0, rega = '0, regb = '0, pc_add_opa = '0;
    logic [SEL_W-1:0] opa_sel = '0, opb_sel = '0;
    logic [NUM_FWD*XLEN-1:0] fwd_data = '0;
    logic [3:0] alu_func = '0;
    logic is_md = 1'b0, cond_branch = 1'b0, uncond_branch = 1'b0;
    logic [2:0] md_op = '0, funct3 = '0;
    logic in_ready, out_valid, out_take_branch, busy;
    logic [XLEN-1:0] out_result, out_target_pc;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    logic m_ov = 1'b0, m_take = 1'b0;
    logic [31:0] m_res = '0, m_tgt = '0, m_pend = '0, m_a, m_b;
    int m_left = 0;
    bit m_acc;

    always #5 clk = ~clk;

    ex_stage_mc #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .pc(pc), .imm(imm), .rega(rega), .regb(regb), .opa_sel(opa_sel), .opb_sel(opb_sel),
        .fwd_data(fwd_data), .alu_func(alu_func), .is_md(is_md), .md_op(md_op),
        .cond_branch(cond_branch), .uncond_branch(uncond_branch), .funct3(funct3),
        .pc_add_opa(pc_add_opa), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_target_pc(out_target_pc),
        .out_take_branch(out_take_branch), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(logic [2:0] sel, logic [31:0] dflt, logic [31:0] one, logic [31:0] two);
        int s = int'(sel);
        if (s == 1) return one;
        if (s == 2) return two;
        if (s >= 3 && s < 3 + NUM_FWD) return fwd_data[(s-3)*32 +: 32];
        return dflt;
    endfunction

    function automatic logic [31:0] alu_model(logic [3:0] f, logic [31:0] a, logic [31:0] b);
        int s = int'(b[4:0]);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << s;
            4'd6: return a >> s;
            4'd7: return 32'($signed(a) >>> s);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] md_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0, 3'd1: p = 64'(sa * sb);
            3'd2:       p = 64'(sa * ub);
            3'd3:       p = 64'(ua * ub);
            3'd4:       p = (b == 0) ? '1 : (a == 32'h8000_0000 && b == '1) ? 64'(a) : 64'(sa / sb);
            3'd5:       p = (b == 0) ? '1 : 64'(ua / ub);
            3'd6:       p = (b == 0) ? 64'(a) : 64'(sa % sb);
            default:    p = (b == 0) ? 64'(a) : 64'(ua % ub);
        endcase
        return (op inside {3'd1, 3'd2, 3'd3}) ? p[63:32] : p[31:0];
    endfunction

    function automatic bit br_model(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_ready();
        return rst && m_left == 0 && (!m_ov || out_ready) && !flush;
    endfunction

    function automatic logic [31:0] rval();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ov = 1'b0; m_res = '0; m_tgt = '0; m_take = 1'b0; m_left = 0;
        end else begin
            m_acc = in_valid && exp_ready();
            m_a = pick(opa_sel, rega, pc, 32'd0);
            m_b = pick(opb_sel, regb, imm, 32'd4);
            if (flush) begin
                m_left = 0; m_ov = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_ov = 1'b1; m_res = m_pend; m_tgt = '0; m_take = 1'b0;
                end
            end else begin
                if (m_ov && out_ready) m_ov = 1'b0;
                if (m_acc && is_md) begin
                    m_left = XLEN;
                    m_pend = md_model(md_op, m_a, m_b);
                end else if (m_acc) begin
                    m_ov   = 1'b1;
                    m_res  = alu_model(alu_func, m_a, m_b);
                    m_tgt  = pc_add_opa + imm;
                    m_take = uncond_branch || (cond_branch && br_model(funct3, rega, regb));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, exp_ready());
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, m_left > 0);
            if (m_ov) begin
                chk("out_result", out_result, m_res);
                chk("out_target_pc", out_target_pc, m_tgt);
                chk("out_take_branch", out_take_branch, m_take);
            end
        end
    end

    task automatic setop(logic [3:0] f, logic md, logic [2:0] mo, logic [2:0] sa, logic [2:0] sb,
                         logic [31:0] ra, logic [31:0] rb, logic [31:0] im);
        alu_func = f; is_md = md; md_op = mo; opa_sel = sa; opb_sel = sb;
        rega = ra; regb = rb; imm = im; cond_branch = 1'b0; uncond_branch = 1'b0; funct3 = '0;
    endtask

    task automatic issue_wait(output int cyc, output int bcyc, output int rdy);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0; bcyc = 0; rdy = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (busy) begin
                bcyc++;
                if (in_ready) rdy++;
            end
            if (out_valid) break;
        end
    endtask

    logic [2:0]  top[8] = '{3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd1, 3'd3, 3'd0};
    logic [31:0] ta[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9, 32'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] tb[8]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    logic [31:0] tr[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF4};

    initial begin
        int cyc, bc, rb, n;
        #2 rst = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_target", out_target_pc, 0);
        chk("rst_take", out_take_branch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        fwd_data[31:0] = 32'd5;
        setop(4'd0, 1'b0, 3'd0, 3'd3, 3'd1, 32'd0, 32'd0, 32'd7);
        issue_wait(cyc, bc, rb);
        chk("add_latency", cyc, 1);
        chk("add_result", out_result, 32'd12);

        for (int i = 0; i < 8; i++) begin
            setop(4'd0, 1'b1, top[i], 3'd0, 3'd0, ta[i], tb[i], 32'd0);
            issue_wait(cyc, bc, rb);
            chk("md_result", out_result, tr[i]);
            chk("md_latency", cyc, 33);
            chk("md_busy_cycles", bc, 32);
            chk("md_ready_in_busy", rb, 0);
        end

        @(posedge clk);
        #1 out_ready = 1'b0;
        setop(4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h20);
        cond_branch = 1'b1; funct3 = 3'd4; pc_add_opa = 32'h100;
        issue_wait(cyc, bc, rb);
        chk("blt_latency", cyc, 1);
        chk("blt_take", out_take_branch, 1);
        chk("blt_target", out_target_pc, 32'h120);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_target", out_target_pc, 32'h120);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1; cond_branch = 1'b0;
        @(negedge clk);
        chk("drain_valid", out_valid, 0);

        setop(4'd0, 1'b1, 3'd5, 3'd0, 3'd0, 32'd100, 32'd7, 32'd0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("flush_no_result", n, 0);

        setop(4'd0, 1'b0, 3'd0, 3'd3, 3'd1, 32'd0, 32'd0, 32'd7);
        uncond_branch = 1'b1;
        issue_wait(cyc, bc, rb);
        chk("jmp_result", out_result, 32'd12);
        chk("jmp_target", out_target_pc, 32'h107);
        setop(4'd0, 1'b1, 3'd4, 3'd0, 3'd0, 32'd100, 32'd7, 32'd0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_result", out_result, 0);
        chk("arst_target", out_target_pc, 0);
        chk("arst_take", out_take_branch, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst           = $urandom_range(0, 499) != 0;
            in_valid      = 1'($urandom_range(0, 1));
            flush         = $urandom_range(0, 39) == 0;
            out_ready     = $urandom_range(0, 3) != 0;
            is_md         = $urandom_range(0, 3) == 0;
            md_op         = 3'($urandom);
            alu_func      = 4'($urandom);
            opa_sel       = 3'($urandom);
            opb_sel       = 3'($urandom);
            rega          = rval();
            regb          = rval();
            imm           = rval();
            pc            = $urandom;
            pc_add_opa    = $urandom;
            fwd_data      = {$urandom, rval(), rval()};
            cond_branch   = 1'($urandom);
            uncond_branch = $urandom_range(0, 3) == 0;
            funct3        = 3'($urandom);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
